mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
- Job-level sequencer in front of the MAC lane: accepts one job configuration (datatype and element count), then streams operand pairs A/B from two valid/ready inputs into the MAC decoder/multiply path.
- Issues a registered operand pair per accepted beat, masking each operand to its datatype width and tagging the first/last beat of the job.
- After the last beat it waits out the MAC pipeline latency, then pulses done. Sits between the operand buffers and the mac_decoder_big instances.

Parameters:
- LEN_W, 16, width of the job element count.
- DRAIN_CYC, 4, cycles between the last beat leaving this block and o_done; must be at least 1.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, synchronous, active-low.
- i_cfg_valid  in  1  job request.
- o_cfg_ready  out  1  high only in IDLE.
- i_cfg_datatype  in  mac_datatype  job datatype.
- i_cfg_len  in  LEN_W  number of operand pairs in the job.
- i_a_valid / o_a_ready  in/out  1  operand A handshake.
- i_a_data  in  16  operand A, packed per datatype.
- i_b_valid / o_b_ready  in/out  1  operand B handshake.
- i_b_data  in  16  operand B.
- o_mac_valid  out  1  issued beat valid.
- i_mac_ready  in  1  downstream accepts beat.
- o_mac_datatype  out  mac_datatype  latched job datatype.
- o_mac_a / o_mac_b  out  16  masked operands.
- o_mac_first  out  1  first beat of job (accumulator clear).
- o_mac_last  out  1  last beat of job.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset (i_rstn low at a clock edge): state IDLE, counters 0, all outputs 0 except o_cfg_ready=1. Reset mid-job abandons the job; no o_done is produced for it.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - o_cfg_ready=1, o_a_ready=o_b_ready=0.
  - On i_cfg_valid, latch datatype and len, clear the issue counter.
  - Go to RUN if len != 0. If len == 0, go to DONE: no beats are issued, and o_done fires the cycle after acceptance.
- RUN, operand acceptance:
  - Output stage is a single register slot; slot_free = !o_mac_valid || i_mac_ready.
  - o_a_ready = i_b_valid && slot_free && cnt < len. o_b_ready is symmetric, so A and B are consumed only together (joint fire).
- RUN, on fire:
  - Load o_mac_a/o_mac_b masked; set o_mac_valid=1.
  - o_mac_first = (cnt == 0); o_mac_last = (cnt == len-1); cnt increments.
- Masking (zeros above the element width):
  - FP16: all 16 bits pass.
  - FP8: bits [15:8] forced 0.
  - Integer (any other mac_datatype value): bits [15:9] forced 0.
  - Purpose: a stale high byte must not defeat the decoder's zero detect.
- If i_mac_ready and no fire occurs, o_mac_valid clears next cycle. Outputs hold stable while o_mac_valid && !i_mac_ready.
- RUN to DRAIN: when the beat with o_mac_last is accepted (o_mac_valid && i_mac_ready && o_mac_last). The drain counter loads DRAIN_CYC-1.
- DRAIN: no handshakes; decrement each cycle; at 0 go to DONE. Beat-accept to o_done latency = DRAIN_CYC+1 cycles.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_cfg_ready is 0 in DONE, so a back-to-back job is accepted the cycle after o_done.
- Operands are never consumed outside RUN; extra valid operands wait.
- Only the latched configuration is used during a job; i_cfg_* changes in RUN are ignored.
- Counter widths: cnt is LEN_W bits. i_cfg_len = 2^LEN_W-1 is legal and must not wrap before the last beat.

Decomposition:
- mac_pkg: mac_datatype (existing), the new state enum mac_seq_state_e, and function mac_operand_mask(datatype, data).
- No sub-module; the masking function is shared with any future packer.

Test Plan:
- Basic FP16 job:
  - Stimulus: len=3, both streams always valid, i_mac_ready=1.
  - Response: 3 consecutive beats; first=1 only on beat 0, last=1 only on beat 2; o_done exactly DRAIN_CYC+1 cycles after beat 2 accepted (5 cycles at default).
- FP8 masking:
  - Stimulus: i_a_data=16'hAB3C, i_b_data=16'hFF80.
  - Response: o_mac_a=16'h003C, o_mac_b=16'h0080.
- Integer-mode masking:
  - Stimulus: integer datatype, i_a_data=16'hFFFF.
  - Response: o_mac_a=16'h01FF.
- Backpressure and skew:
  - Stimulus: len=4, i_mac_ready low 3 cycles mid-job; B valid lags A by 2 cycles.
  - Response: outputs held stable while stalled; no A is consumed without B; exactly 4 beats issued.
- Zero-length job:
  - Stimulus: len=0.
  - Response: no o_mac_valid; o_done one cycle after cfg acceptance; next cfg accepted the following cycle.
- Reset mid-RUN:
  - Stimulus: i_rstn low 1 cycle after beat 1 of len=8.
  - Response: next cycle in IDLE, o_mac_valid=0, no o_done; a new job then runs normally with first=1 on its beat 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC-lane types: operand datatype, sequencer state encoding and the
// operand masking helper used wherever operands are packed for the decoder.
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_DT_INT8 = 2'd0,
    MAC_DT_FP8  = 2'd1,
    MAC_DT_FP16 = 2'd2,
    MAC_DT_INT4 = 2'd3
  } mac_datatype;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } mac_seq_state_e;

  // Zero everything above the element width so a stale high byte cannot
  // defeat the decoder's zero detect. Integer formats carry a 9-bit field.
  function automatic logic [15:0] mac_operand_mask(input mac_datatype dt,
                                                   input logic [15:0] data);
    logic [15:0] masked;
    case (dt)
      MAC_DT_FP16: masked = data;
      MAC_DT_FP8:  masked = {8'h00, data[7:0]};
      default:     masked = {7'h00, data[8:0]};
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// Job-level sequencer: latches one job config, issues masked A/B operand pairs
// into a single-slot output register, waits out the MAC pipeline, pulses done.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int DRAIN_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  mac_datatype       i_cfg_datatype,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [15:0]       i_a_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic [15:0]       i_b_data,
  output logic              o_mac_valid,
  input  logic              i_mac_ready,
  output mac_datatype       o_mac_datatype,
  output logic [15:0]       o_mac_a,
  output logic [15:0]       o_mac_b,
  output logic              o_mac_first,
  output logic              o_mac_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  mac_seq_state_e    state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  mac_datatype       dt_q, dt_d;
  logic [DRN_W-1:0]  drain_q, drain_d;

  logic              mac_valid_q, mac_valid_d;
  logic [15:0]       mac_a_q, mac_a_d;
  logic [15:0]       mac_b_q, mac_b_d;
  logic              mac_first_q, mac_first_d;
  logic              mac_last_q, mac_last_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              in_run_s;
  logic              slot_free_s;
  logic              has_room_s;
  logic              fire_s;
  logic              last_acc_s;

  // cnt < len keeps the count from wrapping even for a full-scale length
  assign in_run_s    = (state_q == SEQ_RUN);
  assign slot_free_s = !mac_valid_q || i_mac_ready;
  assign has_room_s  = (cnt_q < len_q);
  assign o_a_ready   = in_run_s && i_b_valid && slot_free_s && has_room_s;
  assign o_b_ready   = in_run_s && i_a_valid && slot_free_s && has_room_s;
  assign fire_s      = i_a_valid && o_a_ready;
  assign last_acc_s  = mac_valid_q && i_mac_ready && mac_last_q;

  // Job control state machine
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dt_d    = dt_q;
    drain_d = drain_q;
    case (state_q)
      SEQ_IDLE: begin
        if (i_cfg_valid) begin
          len_d   = i_cfg_len;
          dt_d    = i_cfg_datatype;
          cnt_d   = {LEN_W{1'b0}};
          state_d = (i_cfg_len == {LEN_W{1'b0}}) ? SEQ_DONE : SEQ_RUN;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        if (fire_s) begin
          cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if (last_acc_s) begin
          state_d = SEQ_DRAIN;
          drain_d = DRN_W'(DRAIN_CYC - 1);
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_DRAIN: begin
        if (drain_q == {DRN_W{1'b0}}) begin
          state_d = SEQ_DONE;
        end else begin
          drain_d = drain_q - {{(DRN_W-1){1'b0}}, 1'b1};
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // Output slot: load on fire, empty on accept without refill, else hold
  always_comb begin
    mac_valid_d = mac_valid_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_first_d = mac_first_q;
    mac_last_d  = mac_last_q;
    if (fire_s) begin
      mac_valid_d = 1'b1;
      mac_a_d     = mac_operand_mask(dt_q, i_a_data);
      mac_b_d     = mac_operand_mask(dt_q, i_b_data);
      mac_first_d = (cnt_q == {LEN_W{1'b0}});
      mac_last_d  = (cnt_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));
    end else if (i_mac_ready) begin
      mac_valid_d = 1'b0;
    end else begin
      mac_valid_d = mac_valid_q;
    end
  end

  // Status flags registered from the next state
  always_comb begin
    cfg_ready_d = (state_d == SEQ_IDLE);
    busy_d      = (state_d != SEQ_IDLE);
    done_d      = (state_d == SEQ_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= SEQ_IDLE;
      len_q       <= {LEN_W{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      dt_q        <= MAC_DT_INT8;
      drain_q     <= {DRN_W{1'b0}};
      mac_valid_q <= 1'b0;
      mac_a_q     <= 16'h0000;
      mac_b_q     <= 16'h0000;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      dt_q        <= dt_d;
      drain_q     <= drain_d;
      mac_valid_q <= mac_valid_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_cfg_ready    = cfg_ready_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_mac_valid    = mac_valid_q;
  assign o_mac_datatype = dt_q;
  assign o_mac_a        = mac_a_q;
  assign o_mac_b        = mac_b_q;
  assign o_mac_first    = mac_first_q;
  assign o_mac_last     = mac_last_q;

endmodule
